// File: rtl/fft_ctrl_pkg.sv
// fft_ctrl_pkg: shared sizes and state encodings for the FFT frame controller
package fft_ctrl_pkg;
  localparam int N_PTS = 64;
  localparam int SAMPLE_W = 32;
  localparam int PIPE_LAT = 5;
  localparam int IDX_W = $clog2(N_PTS);
  localparam int CNT_W = $clog2(PIPE_LAT) + 1;
  localparam int FRAME_W = N_PTS * SAMPLE_W;
  typedef enum logic {FILL, SETTLE} in_state_t;
  typedef enum logic {IDLE, DRAIN} out_state_t;
endpackage

// File: rtl/fft_obuf_serializer.sv
// fft_obuf_serializer: captures the wide butterfly result and streams it out one word per handshake
module fft_obuf_serializer
  import fft_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                capture,
  input  logic [FRAME_W-1:0]  bf_out,
  input  logic                m_ready,
  output logic                m_valid,
  output logic [SAMPLE_W-1:0] m_data,
  output logic                m_last,
  output logic                last_done
);
  out_state_t state, state_nx;
  logic [IDX_W-1:0] rd_idx;
  logic [FRAME_W-1:0] obuf;
  logic hs;
  assign m_valid = state == DRAIN;
  assign hs = m_valid && m_ready;
  assign m_last = m_valid && rd_idx == IDX_W'(N_PTS - 1);
  assign last_done = hs && m_last;
  assign m_data = m_valid ? obuf[rd_idx*SAMPLE_W +: SAMPLE_W] : '0;
  // a capture coinciding with the last handshake keeps DRAIN for a bubble-free handoff
  always_comb state_nx = capture ? DRAIN : last_done ? IDLE : state;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rd_idx <= '0;
      obuf <= '0;
    end else begin
      state <= state_nx;
      if (capture) begin
        obuf <= bf_out;
        rd_idx <= '0;
      end else if (hs) begin
        rd_idx <= rd_idx + 1'b1;
      end
    end
  end
endmodule

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: assembles sample frames for the butterfly, waits for it to settle, and hands
// the result to the output serializer while the next frame loads
module fft_frame_ctrl
  import fft_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_data,
  input  logic                s_last,
  output logic [FRAME_W-1:0]  bf_in,
  input  logic [FRAME_W-1:0]  bf_out,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [SAMPLE_W-1:0] m_data,
  output logic                m_last,
  output logic                frame_err,
  output logic                busy
);
  in_state_t in_state, in_nx;
  logic [IDX_W-1:0] wr_idx;
  logic [CNT_W-1:0] settle_cnt;
  logic [FRAME_W-1:0] ibuf;
  logic accept, at_end, close, len_err, settled, capture, last_done;
  assign bf_in = ibuf;
  assign s_ready = in_state == FILL;
  assign accept = s_ready && s_valid;
  assign at_end = wr_idx == IDX_W'(N_PTS - 1);
  assign close = accept && (at_end || s_last);
  assign len_err = close && (at_end != s_last);
  assign settled = settle_cnt == CNT_W'(PIPE_LAT - 1);
  // the butterfly result stays valid while SETTLE holds ibuf, so a draining obuf just delays capture
  assign capture = in_state == SETTLE && settled && (!m_valid || last_done);
  assign busy = !(s_ready && wr_idx == '0 && !m_valid);
  always_comb in_nx = close ? SETTLE : capture ? FILL : in_state;
  always_ff @(posedge clk) begin
    if (reset) begin
      in_state <= FILL;
      wr_idx <= '0;
      settle_cnt <= '0;
      ibuf <= '0;
      frame_err <= 1'b0;
    end else begin
      in_state <= in_nx;
      frame_err <= len_err;
      settle_cnt <= (in_state == FILL) ? '0 : settled ? settle_cnt : settle_cnt + 1'b1;
      if (accept) begin
        ibuf[wr_idx*SAMPLE_W +: SAMPLE_W] <= s_data;
        wr_idx <= close ? '0 : wr_idx + 1'b1;
      end
      if (capture) ibuf <= '0;
    end
  end
  fft_obuf_serializer u_ser (
    .clk       (clk),
    .reset     (reset),
    .capture   (capture),
    .bf_out    (bf_out),
    .m_ready   (m_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_last    (m_last),
    .last_done (last_done)
  );
endmodule
